// File: rtl/seven_seg_scan_unit.sv
// seven_seg_scan_unit: scans a 32-bit value (decimal or hex) onto an 8-digit common-anode display
module seven_seg_scan_unit #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int TICK_HZ = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mode,
  input  logic [31:0] input_number,
  input  logic [7:0]  dec_points,
  output logic [6:0]  cathode,
  output logic        dp,
  output logic [7:0]  anode
);
  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] count;
  logic          tick;
  logic [2:0]    idx;
  logic [31:0]   bcd;
  logic [31:0]   disp;
  logic [3:0]    nibble;
  logic [6:0]    seg;
  assign tick = count == CW'(DIV - 1);
  assign disp = mode ? input_number : bcd;
  assign nibble = disp[{idx, 2'b00} +: 4];
  // Double dabble over the low 27 bits; the ninth digit's carry simply falls off the top
  always_comb begin
    bcd = '0;
    for (int b = 26; b >= 0; b--) begin
      for (int d = 0; d < 8; d++)
        bcd[4*d +: 4] = bcd[4*d +: 4] >= 4'd5 ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
      bcd = {bcd[30:0], input_number[b]};
    end
  end
  // Hex nibble to active-low segments, g..a in bits 6..0
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end
  // Scan divider and digit register; the decoded segments are latched at the tick so pins only move on ticks
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      idx <= '0;
      anode <= 8'hFF;
      cathode <= 7'h7F;
      dp <= 1'b1;
    end else begin
      count <= tick ? '0 : count + 1'b1;
      if (tick) begin
        anode <= ~(8'd1 << idx);
        cathode <= seg;
        dp <= ~dec_points[idx];
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_unit.sv
// tb_seven_seg_scan_unit: randomized and directed checks against a digit-level display model
module tb_seven_seg_scan_unit;
  localparam int DIV = 4;
  logic        clock = 0;
  logic        reset = 1;
  logic        mode = 0;
  logic [31:0] input_number = 0;
  logic [7:0]  dec_points = 0;
  logic [6:0]  cathode;
  logic        dp;
  logic [7:0]  anode;
  int tests = 0;
  int fails = 0;
  bit armed = 0;
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  int m_cyc;
  int m_digit;
  logic [7:0] m_an;
  logic [6:0] m_cat;
  logic       m_dp;

  seven_seg_scan_unit #(.CLK_FREQ_HZ(4000), .TICK_HZ(1000)) dut (
    .clock(clock), .reset(reset), .mode(mode), .input_number(input_number),
    .dec_points(dec_points), .cathode(cathode), .dp(dp), .anode(anode)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int digit_of(input logic md, input logic [31:0] num, input int k);
    longint unsigned v;
    if (md) return int'((num >> (4 * k)) & 32'hF);
    v = longint'(num & 32'h07FF_FFFF) % 100000000;
    for (int j = 0; j < k; j++) v = v / 10;
    return int'(v % 10);
  endfunction

  // Reference: every DIV-th cycle since reset lights the next digit with the current input
  always @(posedge clock) begin
    if (reset) begin
      m_cyc = 0; m_digit = 0; m_an = 8'hFF; m_cat = 7'h7F; m_dp = 1'b1;
    end else begin
      m_cyc++;
      if (m_cyc % DIV == 0) begin
        m_an = 8'hFF & ~(8'(1) << m_digit);
        m_cat = seg_tab[digit_of(mode, input_number, m_digit)];
        m_dp = ~dec_points[m_digit];
        m_digit = (m_digit + 1) % 8;
      end
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      check("model_anode", 32'(anode), 32'(m_an));
      check("model_cathode", 32'(cathode), 32'(m_cat));
      check("model_dp", 32'(dp), 32'(m_dp));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    cycles(n);
    reset = 0;
  endtask

  initial begin
    int hex_exp [8] = '{15, 14, 13, 12, 11, 10, 9, 8};
    int d27 [8] = '{9, 8, 7, 6, 5, 4, 3, 2};
    cycles(1);
    do_reset(3);
    armed = 1;
    check("reset_anode", 32'(anode), 32'hFF);
    check("reset_cathode", 32'(cathode), 32'h7F);
    check("reset_dp", 32'(dp), 32'h1);
    // hex rendering, tick timing and wrap
    reset = 1; mode = 1; input_number = 32'h89AB_CDEF; dec_points = 0;
    cycles(3);
    reset = 0;
    cycles(DIV - 1);
    check("pre_tick_anode", 32'(anode), 32'hFF);
    cycles(1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cycles(DIV);
      check("hex_anode", 32'(anode), 32'(8'hFF ^ (8'd1 << k)));
      check("hex_cathode", 32'(cathode), 32'(seg_tab[hex_exp[k]]));
      check("hex_dp", 32'(dp), 32'h1);
    end
    cycles(DIV);
    check("wrap_anode", 32'(anode), 32'hFE);
    // decimal 12345678
    mode = 0; input_number = 12345678;
    do_reset(1);
    cycles(DIV);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cycles(DIV);
      check("dec_cathode", 32'(cathode), 32'(seg_tab[8 - k]));
    end
    check("dec_digit7", 32'(cathode), 32'h79);
    // 27-bit overflow truncation, then upper bits ignored, with one decimal point
    input_number = 123456789; dec_points = 8'b0000_0100;
    do_reset(1);
    cycles(DIV);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cycles(DIV);
      check("trunc_cathode", 32'(cathode), 32'(seg_tab[d27[k]]));
      check("dp_digit", 32'(dp), (k == 2) ? 32'h0 : 32'h1);
    end
    input_number = 32'hF800_0005;
    do_reset(1);
    cycles(DIV);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cycles(DIV);
      check("upper_ignored", 32'(cathode), 32'(seg_tab[k == 0 ? 5 : 0]));
    end
    // reset while digit 3 is lit
    do_reset(1);
    cycles(4 * DIV);
    check("mid_anode_f7", 32'(anode), 32'hF7);
    do_reset(1);
    check("mid_reset_anode", 32'(anode), 32'hFF);
    check("mid_reset_cathode", 32'(cathode), 32'h7F);
    cycles(DIV - 1);
    check("mid_hold_anode", 32'(anode), 32'hFF);
    cycles(1);
    check("mid_resume_anode", 32'(anode), 32'hFE);
    // random inputs at random instants; the model checker covers every cycle
    for (int r = 0; r < 60; r++) begin
      mode = 1'($urandom);
      input_number = $urandom;
      dec_points = 8'($urandom);
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
      cycles($urandom_range(1, 40));
    end
    armed = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_unit.md
Name: seven_seg_scan_unit

Overview:
Drives an 8-digit multiplexed common-anode seven-segment display from a 32-bit value.
- Combines three functions: a 1 ms scan-tick divider, a 27-bit binary-to-BCD converter and a hex-to-segment decoder with decimal point.
- Mode selects decimal (BCD) or hexadecimal rendering.
- Sits between the datapath result register and the board display pins.

Parameters:
CLK_FREQ_HZ, 100000000, input clock frequency.
TICK_HZ, 1000, digit scan rate; divide ratio DIV = CLK_FREQ_HZ/TICK_HZ (100000 default; bench uses DIV=4 via CLK_FREQ_HZ=4000).

Ports:
clock  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high.
mode  input  1  0 = decimal, 1 = hexadecimal.
input_number  input  32  value to display.
dec_points  input  8  per-digit decimal point enable, bit i = digit i, 1 = lit.
cathode  output  7  segment drives, active-low; cathode[0]=a … cathode[6]=g.
dp  output  1  decimal-point drive, active-low.
anode  output  8  digit enables, active-low; anode[0] = rightmost digit.

Behaviour:
Reset (sampled on clock edge while reset=1):
- anode=8'hFF, cathode=7'h7F, dp=1.
- Digit index=0, divider count=0.

Tick divider:
- Counter 0..DIV-1, one-clock internal tick when count==DIV-1, then wraps to 0.
- First tick on the DIV-th rising edge after reset deasserts.

Binary-to-BCD:
- Combinational shift-add-3 (double dabble) on input_number[26:0]; bits 31:27 are ignored in decimal mode.
- Produces 8 BCD digits, digit k in bits [4k+3:4k].
- Values above 99,999,999 are truncated to the value mod 10^8 (ninth digit dropped).

Display word:
- disp = mode ? input_number : BCD result.
- Evaluated combinationally, so a mode change takes effect at the next tick.

Scan, on each tick with digit index i:
- anode = all ones except bit i = 0.
- Nibble register ← disp[4i+3:4i].
- dp ← ~dec_points[i].
- i ← (i+1) mod 8, so 7 wraps to 0.
- Outputs hold between ticks. A full refresh takes 8 ticks.

Segment decode (registered nibble → cathode, combinational), with cathode listed as g..a bits 6..0:
- 0: 1000000; 1: 1111001; 2: 0100100; 3: 0110000
- 4: 0011001; 5: 0010010; 6: 0000010; 7: 1111000
- 8: 0000000; 9: 0010000; A: 0001000; b: 0000011
- C: 1000110; d: 0100001; E: 0000110; F: 0001110
- In decimal mode only 0–9 occur.

Reset mid-scan:
- Forces the reset values on that edge.
- Scan restarts at digit 0 after DIV cycles.
- Reset has priority over a coincident tick.

Other rules:
- Leading zeros are displayed; there is no blanking.
- input_number changes are sampled only at ticks; there are no glitches between ticks.

Test Plan:
- Reset held 3 cycles, DIV=4 → anode=FF, cathode=7F, dp=1; after release, first anode change on 4th edge, anode=FE.
- mode=1, input_number=32'h89ABCDEF, dec_points=0 → successive ticks give anode FE,FD,…,7F with cathode F(0001110), E, d, C, b, A, 9, 8; the 9th tick returns to FE.
- mode=0, input_number=12345678 → digits 0..7 show 8,7,6,5,4,3,2,1; digit0 cathode=0000000, digit7 cathode=1111001.
- mode=0, input_number=123456789 (27-bit) → displays 23456789; input_number=32'hF8000005 displays 00000005 (upper bits ignored).
- dec_points=8'b00000100 → dp=0 only while anode=FB, dp=1 for all other digits.
- Assert reset while anode=F7 → next edge anode=FF; scan resumes at FE after DIV cycles.
